// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared types and sizing for the inter-layer sequencer
package layer_seq_pkg;

   localparam int NUM_NEURONS_DEF = 30;
   localparam int DATAWIDTH_DEF   = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } seq_state_t;

   // Clamped so a single-neuron layer still gets a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_w(NUM_NEURONS_DEF);

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - parallel capture bus in, serial layer stream out
interface layer_sequencer_if
   import layer_seq_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int DATAWIDTH   = DATAWIDTH_DEF
);
   logic [DATAWIDTH*NUM_NEURONS-1:0] x_in;
   logic [NUM_NEURONS-1:0]           x_valid;
   logic [DATAWIDTH-1:0]             data_out;
   logic                             data_valid;
   logic                             data_last;

   modport master (
      output x_in, x_valid,
      input  data_out, data_valid, data_last
   );

   modport slave (
      input  x_in, x_valid,
      output data_out, data_valid, data_last
   );
endinterface

// File: rtl/layer_seq_capture.sv
// rtl/layer_seq_capture.sv - per-neuron capture bank, flags, completion and overrun
// Repeat-capture policy selected by LAYER_SEQ_OVERRUN_EN (keep first + sticky flag) vs last-wins.
module layer_seq_capture
   import layer_seq_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int DATAWIDTH   = DATAWIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATAWIDTH*NUM_NEURONS-1:0] x_in,
   input  logic [NUM_NEURONS-1:0]           x_valid,
   input  logic                             clear,
   output logic [DATAWIDTH*NUM_NEURONS-1:0] bank,
   output logic                             complete,
   output logic                             overrun
);

   logic [NUM_NEURONS-1:0]           flag_q;
   logic [NUM_NEURONS-1:0]           wr_en;
   logic [DATAWIDTH*NUM_NEURONS-1:0] bank_q;

`ifdef LAYER_SEQ_OVERRUN_EN
   logic [NUM_NEURONS-1:0] repeat_hit;
   logic                   overrun_q;

   // A capture coinciding with the transfer lands in a freshly cleared bank.
   assign repeat_hit = clear ? '0 : (flag_q & x_valid);
   assign wr_en      = x_valid & ~repeat_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (|repeat_hit) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun = overrun_q;
`else
   assign wr_en   = x_valid;
   assign overrun = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q <= '0;
      end else begin
         flag_q <= (clear ? '0 : flag_q) | x_valid;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (wr_en[i]) begin
            bank_q[i*DATAWIDTH +: DATAWIDTH] <= x_in[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   assign bank     = bank_q;
   assign complete = &flag_q;

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - double-buffered capture-to-serial replay between neuron layers
// Optional LAYER_SEQ_OVERRUN_EN changes repeat-capture handling inside layer_seq_capture.
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int DATAWIDTH   = DATAWIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   layer_sequencer_if.slave   bus,
   output logic               busy,
   output logic               overrun
);

   localparam int                   IW       = idx_w(NUM_NEURONS);
   localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_NEURONS - 1);

   seq_state_t                       state_q, state_d;
   logic [IW-1:0]                    idx_q, idx_d;
   logic [DATAWIDTH-1:0]             shift_buf [NUM_NEURONS];
   logic [DATAWIDTH*NUM_NEURONS-1:0] bank;
   logic                             complete;
   logic                             transfer;
   logic                             last_elem;
   logic [DATAWIDTH-1:0]             out_data;
   logic                             out_valid;

   layer_seq_capture #(
      .NUM_NEURONS (NUM_NEURONS),
      .DATAWIDTH   (DATAWIDTH)
   ) u_capture (
      .clk      (clk),
      .rst      (rst),
      .x_in     (bus.x_in),
      .x_valid  (bus.x_valid),
      .clear    (transfer),
      .bank     (bank),
      .complete (complete),
      .overrun  (overrun)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (transfer) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            shift_buf[i] <= bank[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // A bank already complete by the last element's cycle streams with no bubble.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_elem = (state_q == SHIFT) && (idx_q == LAST_IDX);
      transfer  = complete && ((state_q == IDLE) || last_elem);
      out_valid = 1'b0;
      out_data  = '0;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               state_d = SHIFT;
               idx_d   = '0;
            end
         end
         SHIFT: begin
            out_valid = 1'b1;
            out_data  = shift_buf[idx_q];
            if (last_elem) begin
               state_d = transfer ? SHIFT : IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign bus.data_out   = out_data;
   assign bus.data_valid = out_valid;
   assign bus.data_last  = last_elem;
   assign busy           = out_valid;

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Inter-layer controller for the MNIST fully connected pipeline. It collects the parallel outputs of one neuron layer into a capture bank, tolerating per-neuron valid skew. It then replays the values serially, neuron 0 first, as the one-value-per-cycle input stream the next layer's neurons consume. A double-buffered capture/shift structure lets the next image's layer outputs be gathered while the current one is being streamed.

## Interface
- NUM_NEURONS, 30: neurons in the upstream layer; values streamed per frame
- DATAWIDTH, 16: fixed-point word width, unchanged from the neuron datapath
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- x_in  in  DATAWIDTH*NUM_NEURONS  upstream layer outputs; neuron i at [i*DATAWIDTH +: DATAWIDTH]
- x_valid  in  NUM_NEURONS  per-neuron single-cycle output-valid strobes
- data_out  out  DATAWIDTH  serial value to next layer (input_val)
- data_valid  out  1  serial strobe to next layer (input_valid)
- data_last  out  1  high with the element from neuron NUM_NEURONS-1
- busy  out  1  shifter in SHIFT state
- overrun  out  1  sticky capture-overrun flag

## Operation
- Capture bank: per-neuron register plus flag. x_valid[i] loads x_in slice i and sets flag[i].
- complete = AND of all flags, evaluated from registered flags.
- Transfer condition: complete && (state==IDLE || (state==SHIFT && idx==NUM_NEURONS-1)).
- On transfer: copy bank to shift buffer, clear all flags, idx<=0, state<=SHIFT.
- SHIFT state:
  - data_out = shift_buf[idx], data_valid=1, idx increments each cycle.
  - At idx==NUM_NEURONS-1: data_last=1; next state is SHIFT (if transfer) else IDLE.
- IDLE state: data_valid=0, data_last=0, data_out=0.
- There is no backpressure. The downstream accepts one value per cycle.
- Simultaneous x_valid[i] and transfer: the flag clear and the transfer take effect first; the new value loads the fresh bank with flag[i]=1. Nothing is lost and overrun is not raised.
- x_valid[i] while flag[i] already set is an overrun; handling is given under Configuration.
- idx width is clog2(NUM_NEURONS) and wraps only through the transfer/IDLE logic, never by overflow.

## Timing
- Reset values: all flags 0, state IDLE, idx 0, data_out 0, data_valid 0, data_last 0, busy 0, overrun 0. Bank and shift contents are don't-care.
- rst asserted mid-SHIFT: all outputs are at reset values in the cycle after the edge. Partially collected flags are discarded.
- Latency: the last missing x_valid, high in cycle c, gives the first data_valid in cycle c+2. Elements 0..NUM_NEURONS-1 appear in cycles c+2..c+NUM_NEURONS+1.
- Back-to-back frames: a bank that is complete by the last element's cycle streams with zero bubble.
- A bank that completes later starts 1 cycle after complete is seen in IDLE.

## Configuration
- LAYER_SEQ_OVERRUN_EN defined:
  - A repeat x_valid[i] with flag[i] set is dropped; the first value is kept.
  - overrun is set to 1 and held until rst.
- LAYER_SEQ_OVERRUN_EN undefined:
  - A repeat x_valid[i] overwrites the bank entry; the last value wins.
  - overrun is tied 0.

## Structure
- Package layer_seq_pkg holds:
  - state enum (IDLE, SHIFT)
  - IDX_W = clog2(NUM_NEURONS) helper
  - default DATAWIDTH/NUM_NEURONS constants shared with the layer wrappers
- Sub-module layer_seq_capture holds the bank registers, flags, complete, and overrun logic. The top level holds the FSM and shift buffer.

## Test plan
All scenarios use NUM_NEURONS=30 and DATAWIDTH=16.
- Aligned frame: all x_valid high in cycle 5, x_in slice i = 16'h0100+i. Required: data_valid cycles 7..36, data_out 16'h0100..16'h011D in order, data_last only in cycle 36, busy 7..36.
- Skewed frame: neurons 0–14 valid in cycle 5, neurons 15–29 valid in cycle 9. Required: first data_valid in cycle 11 and correct values.
- Back-to-back frames: second frame fully valid in cycle 20, during the first frame's shift. Required: data_valid continuous over cycles 7..66, data_last in cycles 36 and 66.
- Overrun: x_valid[3] with 16'h1111 in cycle 2, then 16'h2222 in cycle 3; the others complete in cycle 4. Required, macro on: element 3 = 16'h1111 and overrun=1 from cycle 4. Required, macro off: element 3 = 16'h2222 and overrun=0.
- Coincident capture: x_valid[0] in the transfer-edge cycle. Required: captured into the next frame, not lost, no overrun.
- Reset mid-shift: rst at element 10, with 15 flags of the next frame set. Required: data_valid/busy 0 next cycle. A subsequent full frame streams only its own values.
